// File: rtl/adder_pkg.sv
// Shared definitions for the lab adder/subtractor blocks.
// State encoding and default operand width.
package adder_pkg;

  localparam int ADDER_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the serial subtractor.
// master = operand source and result consumer, slave = subtractor.
interface serial_subtractor_if
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, overflow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, overflow
  );

endinterface

// File: rtl/full_adder.sv
// One-bit full adder shared by the ripple and serial arithmetic blocks.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b: one full_adder evaluates a + ~b + 1 LSB first, one bit per cycle.
// Result, borrow and signed overflow are held in DONE until the consumer takes them.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | in_ready high, waiting for in_valid
// ST_SHIFT | one operand bit per cycle through the full adder
// ST_DONE  | out_valid high, result held until out_ready
module serial_subtractor
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   sh_a;
  logic [WIDTH-1:0]   sh_b;
  logic [WIDTH-2:0]   res_q;
  logic [WIDTH-1:0]   res_next;
  logic [WIDTH-1:0]   diff_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic               borrow_q;
  logic               overflow_q;
  logic               fa_sum;
  logic               fa_cout;
  logic               accept;
  logic               shift_en;
  logic               last_bit;

  full_adder u_fa (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last_bit = (cnt_q == LAST_BIT);
  // Earlier sum bits sit below the newest one; on the last bit this is the full difference.
  assign res_next = {fa_sum, res_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    shift_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        if (last_bit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a       <= '0;
      sh_b       <= '0;
      res_q      <= '0;
      diff_q     <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else if (accept) begin
      sh_a    <= bus.a;
      sh_b    <= ~bus.b;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b1;
    end else if (shift_en) begin
      sh_a    <= sh_a >> 1;
      sh_b    <= sh_b >> 1;
      res_q   <= res_next[WIDTH-1:1];
      carry_q <= fa_cout;
      cnt_q   <= cnt_q + CNT_W'(1);
      if (last_bit) begin
        diff_q     <= res_next;
        borrow_q   <= ~fa_cout;
        overflow_q <= carry_q ^ fa_cout;
      end
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=3) with a cycle-level reference model
// and a per-cycle compare process, plus literal expectations for the named scenarios.
module tb_serial_subtractor;
  import adder_pkg::*;

  localparam int W    = 3;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference arithmetic from plain integers.
  function automatic void ref_sub(input int a, input int b, output int d, output int bo,
                                  output int ov);
    int sa, sb, sd;
    d  = (a - b) & MASK;
    bo = (a < b) ? 1 : 0;
    sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    sd = sa - sb;
    ov = ((sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)))) ? 1 : 0;
  endfunction

  // Cycle-level model: idle / busy for W edges / done until consumed.
  typedef enum {M_IDLE, M_BUSY, M_DONE} mphase_t;
  mphase_t m_phase  = M_IDLE;
  int      m_left   = 0;
  int      m_diff   = 0;
  int      m_borrow = 0;
  int      m_ovf    = 0;
  int      p_diff, p_borrow, p_ovf;

  always @(posedge clk) begin
    if (rst) begin
      m_phase  = M_IDLE;
      m_diff   = 0;
      m_borrow = 0;
      m_ovf    = 0;
    end else begin
      case (m_phase)
        M_IDLE: if (bus.in_valid === 1'b1) begin
          ref_sub(int'(bus.a), int'(bus.b), p_diff, p_borrow, p_ovf);
          m_left  = W;
          m_phase = M_BUSY;
        end
        M_BUSY: begin
          m_left--;
          if (m_left == 0) begin
            m_phase  = M_DONE;
            m_diff   = p_diff;
            m_borrow = p_borrow;
            m_ovf    = p_ovf;
          end
        end
        M_DONE: if (bus.out_ready === 1'b1) m_phase = M_IDLE;
        default: m_phase = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_in_ready", bus.in_ready, (m_phase == M_IDLE));
      check("model_out_valid", bus.out_valid, (m_phase == M_DONE));
      check("model_diff", bus.diff, m_diff);
      check("model_borrow", bus.borrow, m_borrow);
      check("model_overflow", bus.overflow, m_ovf);
    end
  end

  task automatic wait_ready(input string name);
    int k = 0;
    while (bus.in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check({name, "_ready_timeout"}, 0, 1);
  endtask

  // Called at a negedge with in_ready high; returns at the negedge where out_valid is seen.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit scramble,
                        output int lat);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (lat < 50) begin
      if (scramble) begin
        bus.a = W'($urandom_range(0, MASK));
        bus.b = W'($urandom_range(0, MASK));
      end
      @(negedge clk);
      lat++;
      if (bus.out_valid === 1'b1) break;
    end
  endtask

  task automatic op_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int e_diff, input int e_borrow, input int e_ovf);
    int lat;
    wait_ready(name);
    run_op(a, b, 1'b0, lat);
    check({name, "_latency"}, lat, 3);
    check({name, "_diff"}, bus.diff, e_diff);
    check({name, "_borrow"}, bus.borrow, e_borrow);
    check({name, "_overflow"}, bus.overflow, e_ovf);
    @(negedge clk);
    check({name, "_valid_one_cycle"}, bus.out_valid, 0);
    check({name, "_ready_after"}, bus.in_ready, 1);
  endtask

  initial begin
    int lat;
    int e_d, e_b, e_o;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_diff", bus.diff, 0);
    check("reset_borrow", bus.borrow, 0);
    check("reset_overflow", bus.overflow, 0);
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    op_check("sub_3_1", 3'd3, 3'd1, 2, 0, 0);
    op_check("sub_1_3", 3'd1, 3'd3, 6, 1, 0);
    op_check("sub_3_5", 3'd3, 3'd5, 6, 1, 1);

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        wait_ready("sweep");
        run_op(W'(i), W'(j), 1'b0, lat);
        ref_sub(i, j, e_d, e_b, e_o);
        check("sweep_latency", lat, 3);
        check("sweep_diff", bus.diff, e_d);
        check("sweep_borrow", bus.borrow, e_b);
        check("sweep_overflow", bus.overflow, e_o);
      end
    end

    // Backpressure: result held, in_valid pulses ignored.
    @(negedge clk);
    wait_ready("hold");
    bus.out_ready = 1'b0;
    run_op(3'd7, 3'd7, 1'b0, lat);
    check("hold_latency", lat, 3);
    for (int k = 0; k < 5; k++) begin
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_diff", bus.diff, 0);
      check("hold_in_ready", bus.in_ready, 0);
      bus.a        = 3'd1;
      bus.b        = 3'd0;
      bus.in_valid = (k % 2 == 0);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("hold_consumed", bus.out_valid, 0);
    check("hold_idle", bus.in_ready, 1);
    @(negedge clk);
    check("hold_not_queued", bus.in_ready, 1);

    // Operands scrambled during SHIFT must not matter.
    wait_ready("scramble");
    run_op(3'd5, 3'd2, 1'b1, lat);
    check("scramble_latency", lat, 3);
    check("scramble_diff", bus.diff, 3);
    check("scramble_borrow", bus.borrow, 0);
    @(negedge clk);

    // Reset in the middle of an operation.
    wait_ready("abort");
    bus.a        = 3'd6;
    bus.b        = 3'd1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_diff", bus.diff, 0);
    check("abort_borrow", bus.borrow, 0);
    op_check("sub_2_2", 3'd2, 3'd2, 0, 0, 0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
